bram_add_ctrl: RTL and testbench

//  Sequencer for the BRAM adder datapath. On start, it streams LEN words from two 256x16 single-port BRAMs
//  (operand A, operand B) at the same addresses, adds them element-wise, and writes the sums into a third

---
 rtl/bram_add_pkg.sv | 23 ++
 rtl/bram_add_if.sv | 40 ++++
 rtl/bram_add_pipe.sv | 42 ++++
 rtl/bram_add_ctrl.sv | 136 +++++++++++++
 tb/tb_bram_add_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_add_pkg.sv
// rtl/bram_add_pkg.sv - shared types and defaults for the BRAM adder sequencer
package bram_add_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int rd_lat_clamp(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/bram_add_if.sv
// rtl/bram_add_if.sv - control and three-BRAM bus of the adder sequencer
interface bram_add_if
  import bram_add_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              ovf;

  logic              ena_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] dout_a;
  logic              ena_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] dout_b;
  logic              ena_c;
  logic              wea_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] din_c;

  modport master (
    output start, src_addr, dst_addr, len, dout_a, dout_b,
    input  busy, done, ovf, ena_a, addr_a, ena_b, addr_b,
    input  ena_c, wea_c, addr_c, din_c
  );

  modport slave (
    input  start, src_addr, dst_addr, len, dout_a, dout_b,
    output busy, done, ovf, ena_a, addr_a, ena_b, addr_b,
    output ena_c, wea_c, addr_c, din_c
  );

endinterface

// File: rtl/bram_add_pipe.sv
// rtl/bram_add_pipe.sv - delay line carrying {valid, element offset} for in-flight reads
module bram_add_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         tap_valid_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o
);

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0][W-1:0] data_q, data_d;

  always_comb begin
    valid_d   = {valid_q[DEPTH-2:0], valid_i};
    data_d    = data_q;
    data_d[0] = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // The second-to-last stage lines up with read data; the last with the write.
  assign tap_valid_o = valid_q[DEPTH-2];
  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/bram_add_ctrl.sv
// rtl/bram_add_ctrl.sv - streams A+B into result BRAM; BRAM_ADD_SAT_EN selects saturating sums
module bram_add_ctrl
  import bram_add_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  bram_add_if.slave bus
);

  localparam int LAT   = rd_lat_clamp(RD_LAT);
  localparam int LEN_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              ovf_q, ovf_d;

  logic              run;
  logic              cap_valid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_off;
  logic              last_rd;
  logic              last_wr;
  logic [DATA_W:0]   sum_full;
  logic              carry;
  logic [DATA_W-1:0] sum_sel;

  assign run = (state_q == ST_RUN);

  bram_add_pipe #(
    .DEPTH (LAT + 1),
    .W     (ADDR_W)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (run),
    .data_i      (k_q),
    .tap_valid_o (cap_valid),
    .out_valid_o (wr_valid),
    .out_data_o  (wr_off)
  );

  assign last_rd = ({1'b0, k_q} == len_q - LEN_W'(1));
  assign last_wr = wr_valid && ({1'b0, wr_off} == len_q - LEN_W'(1));

  assign sum_full = {1'b0, bus.dout_a} + {1'b0, bus.dout_b};
  assign carry    = sum_full[DATA_W];

`ifdef BRAM_ADD_SAT_EN
  assign sum_sel = carry ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];
`else
  assign sum_sel = sum_full[DATA_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    k_d     = k_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          src_d   = bus.src_addr;
          dst_d   = bus.dst_addr;
          len_d   = bus.len;
          k_d     = '0;
          ovf_d   = 1'b0;
          state_d = (bus.len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        k_d = k_q + ADDR_W'(1);
        if (last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_wr) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture never coincides with an accepted start, so the ovf clear cannot be lost.
    if (cap_valid) begin
      sum_d = sum_sel;
      if (carry) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy   = run || (state_q == ST_DRAIN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.ovf    = ovf_q;

  assign bus.ena_a  = run;
  assign bus.addr_a = run ? (src_q + k_q) : '0;
  assign bus.ena_b  = run;
  assign bus.addr_b = run ? (src_q + k_q) : '0;

  assign bus.ena_c  = wr_valid;
  assign bus.wea_c  = wr_valid;
  assign bus.addr_c = wr_valid ? (dst_q + wr_off) : '0;
  assign bus.din_c  = wr_valid ? sum_q : '0;

endmodule

// File: tb/tb_bram_add_ctrl.sv
// tb/tb_bram_add_ctrl.sv - lanes at read latency 1 and 2 checked against a cycle-level job model
module tb_bram_add_ctrl;

  localparam int NL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0]       rst_v;
  logic                start;
  logic [7:0]          src, dst;
  logic [8:0]          len;
  logic                fill_req;

  logic [NL-1:0]       busy_v, done_v, ovf_v, ena_a_v, ena_b_v, ena_c_v, wea_c_v;
  logic [NL-1:0][7:0]  addr_a_v, addr_b_v, addr_c_v;
  logic [NL-1:0][15:0] din_c_v, dout_a_v, dout_b_v;
  logic [NL-1:0][2:0][15:0] rda_q, rdb_q;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] mem_c [NL][256];

  for (genvar g = 0; g < NL; g++) begin : lane
    bram_add_if #(.ADDR_W(8), .DATA_W(16)) bif ();
    assign bif.start    = start;
    assign bif.src_addr = src;
    assign bif.dst_addr = dst;
    assign bif.len      = len;
    assign bif.dout_a   = dout_a_v[g];
    assign bif.dout_b   = dout_b_v[g];
    assign busy_v[g]    = bif.busy;
    assign done_v[g]    = bif.done;
    assign ovf_v[g]     = bif.ovf;
    assign ena_a_v[g]   = bif.ena_a;
    assign addr_a_v[g]  = bif.addr_a;
    assign ena_b_v[g]   = bif.ena_b;
    assign addr_b_v[g]  = bif.addr_b;
    assign ena_c_v[g]   = bif.ena_c;
    assign wea_c_v[g]   = bif.wea_c;
    assign addr_c_v[g]  = bif.addr_c;
    assign din_c_v[g]   = bif.din_c;
    assign dout_a_v[g]  = rda_q[g][g];
    assign dout_b_v[g]  = rdb_q[g][g];

    bram_add_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_LAT(g + 1)) dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bif)
    );
  end

  // BRAM models: lane g presents read data g+1 clocks after the enable edge
  always @(posedge clk) begin
    for (int g = 0; g < NL; g++) begin
      rda_q[g][0] <= ena_a_v[g] ? mem_a[addr_a_v[g]] : rda_q[g][0];
      rdb_q[g][0] <= ena_b_v[g] ? mem_b[addr_b_v[g]] : rdb_q[g][0];
      rda_q[g][1] <= rda_q[g][0];
      rdb_q[g][1] <= rdb_q[g][0];
      rda_q[g][2] <= rda_q[g][1];
      rdb_q[g][2] <= rdb_q[g][1];
      if (fill_req) begin
        for (int i = 0; i < 256; i++) mem_c[g][i] <= 16'hC000 | 16'(i);
      end else if (ena_c_v[g] && wea_c_v[g]) begin
        mem_c[g][addr_c_v[g]] <= din_c_v[g];
      end
    end
  end

  int          cyc, n_tests, n_fail;
  bit          job_on   [NL];
  int          t0       [NL];
  int          jsrc     [NL];
  int          jdst     [NL];
  int          jlen     [NL];
  int          done_rel [NL];
  int          wr_cnt   [NL];
  bit          ovf_prev [NL];
  bit          cy       [NL][256];
  logic [15:0] sumv     [NL][256];

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d cyc %0d: got 0x%0h expected 0x%0h", nm, g, cyc, act, exp);
    end
  endtask

  // Job model: cycle c after acceptance -> reads at 1..L, writes at 2+R..1+L+R, done at 2+L+R
  task automatic model_check();
    logic        e_busy, e_done, e_ovf, e_ena_a, e_ena_c, fin, o, idle;
    logic [7:0]  e_addr_a, e_addr_c;
    logic [15:0] e_din;
    logic [16:0] s;
    int          c, R, L, k, end_c, ai;
    for (int g = 0; g < NL; g++) begin
      e_busy = 0; e_done = 0; e_ena_a = 0; e_ena_c = 0;
      e_addr_a = '0; e_addr_c = '0; e_din = '0;
      e_ovf = ovf_prev[g];
      R = g + 1;
      L = jlen[g];
      c = cyc - t0[g];
      end_c = (L == 0) ? 1 : 2 + L + R;
      fin = 0;
      for (int j = 0; j < L; j++) fin |= cy[g][j];
      if (rst_v[g]) begin
        e_ovf = 0;
        job_on[g] = 0;
        ovf_prev[g] = 0;
      end else if (job_on[g]) begin
        if (L == 0) begin
          e_done = (c == 1);
          e_ovf  = 0;
        end else begin
          e_busy = (c >= 1 && c <= 1 + L + R);
          e_done = (c == 2 + L + R);
          if (c >= 1 && c <= L) begin
            e_ena_a  = 1;
            e_addr_a = 8'((jsrc[g] + c - 1) % 256);
          end
          if (c >= 2 + R && c <= 1 + L + R) begin
            k = c - 2 - R;
            e_ena_c  = 1;
            e_addr_c = 8'((jdst[g] + k) % 256);
            e_din    = sumv[g][k];
          end
          o = 0;
          for (int j = 0; j < L; j++) if (j + 2 + R <= c) o |= cy[g][j];
          e_ovf = o;
        end
      end
      chk("busy",   g, 32'(busy_v[g]),   32'(e_busy));
      chk("done",   g, 32'(done_v[g]),   32'(e_done));
      chk("ovf",    g, 32'(ovf_v[g]),    32'(e_ovf));
      chk("ena_a",  g, 32'(ena_a_v[g]),  32'(e_ena_a));
      chk("addr_a", g, 32'(addr_a_v[g]), 32'(e_addr_a));
      chk("ena_b",  g, 32'(ena_b_v[g]),  32'(e_ena_a));
      chk("addr_b", g, 32'(addr_b_v[g]), 32'(e_addr_a));
      chk("ena_c",  g, 32'(ena_c_v[g]),  32'(e_ena_c));
      chk("wea_c",  g, 32'(wea_c_v[g]),  32'(e_ena_c));
      chk("addr_c", g, 32'(addr_c_v[g]), 32'(e_addr_c));
      chk("din_c",  g, 32'(din_c_v[g]),  32'(e_din));
      if (job_on[g] && done_v[g]) done_rel[g] = c;
      if (ena_c_v[g]) wr_cnt[g]++;
      idle = !rst_v[g] && !job_on[g];
      if (job_on[g] && c == end_c) begin
        ovf_prev[g] = fin;
        job_on[g]   = 0;
      end
      if (idle && start) begin
        job_on[g]   = 1;
        t0[g]       = cyc;
        jsrc[g]     = int'(src);
        jdst[g]     = int'(dst);
        jlen[g]     = int'(len);
        done_rel[g] = -1;
        wr_cnt[g]   = 0;
        for (int j = 0; j < jlen[g]; j++) begin
          ai = (jsrc[g] + j) % 256;
          s  = {1'b0, mem_a[ai]} + {1'b0, mem_b[ai]};
          cy[g][j] = s[16];
`ifdef BRAM_ADD_SAT_EN
          sumv[g][j] = s[16] ? 16'hFFFF : s[15:0];
`else
          sumv[g][j] = s[15:0];
`endif
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l, input int mid);
    int n;
    start = 1'b1; src = s; dst = d; len = l;
    step();
    start = 1'b0;
    n = 0;
    while ((job_on[0] || job_on[1]) && n < 700) begin
      if (n == mid) begin
        start = 1'b1; src = 8'h33; dst = 8'h44; len = 9'd5;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    chk("job_ends", 0, 32'(job_on[0] | job_on[1]), 32'd0);
  endtask

  initial begin
    int  n;
    logic [NL-1:0] hit;
    cyc = 0; n_tests = 0; n_fail = 0;
    start = 1'b0; src = '0; dst = '0; len = '0; fill_req = 1'b0;
    rst_v = '1;
    for (int g = 0; g < NL; g++) begin
      job_on[g] = 0; t0[g] = 0; jsrc[g] = 0; jdst[g] = 0; jlen[g] = 0;
      done_rel[g] = -1; wr_cnt[g] = 0; ovf_prev[g] = 0;
    end
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'(i);
      mem_b[i] = 16'(2 * i);
    end
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    step();
    step();
    rst_v = '0;
    step();

    // 1: basic element-wise sum
    run_job(8'h00, 8'h80, 9'd4, -1);
    for (int g = 0; g < NL; g++) begin
      for (int i = 0; i < 4; i++) chk("t1_mem", g, 32'(mem_c[g][8'h80 + i]), 32'(3 * i));
      chk("t1_done_cyc", g, 32'(done_rel[g]), 32'(6 + g + 1));
      chk("t1_ovf", g, 32'(ovf_v[g]), 32'd0);
    end

    // 2: single overflowing element
    mem_a[8'h10] = 16'hFFFF;
    mem_b[8'h10] = 16'h0002;
    run_job(8'h10, 8'h40, 9'd1, -1);
    step();
    for (int g = 0; g < NL; g++) begin
`ifdef BRAM_ADD_SAT_EN
      chk("t2_mem", g, 32'(mem_c[g][8'h40]), 32'h0000FFFF);
`else
      chk("t2_mem", g, 32'(mem_c[g][8'h40]), 32'h00000001);
`endif
      chk("t2_ovf_sticky", g, 32'(ovf_v[g]), 32'd1);
    end
    mem_a[8'h10] = 16'h0010;
    mem_b[8'h10] = 16'h0020;

    // 3: source address wrap
    run_job(8'hFE, 8'h20, 9'd3, -1);
    for (int g = 0; g < NL; g++) begin
      chk("t3_mem0", g, 32'(mem_c[g][8'h20]), 32'h2FA);
      chk("t3_mem1", g, 32'(mem_c[g][8'h21]), 32'h2FD);
      chk("t3_mem2", g, 32'(mem_c[g][8'h22]), 32'h000);
      chk("t3_ovf_cleared", g, 32'(ovf_v[g]), 32'd0);
    end

    // 4: zero-length job
    run_job(8'h05, 8'h06, 9'd0, -1);
    for (int g = 0; g < NL; g++) begin
      chk("t4_done_cyc", g, 32'(done_rel[g]), 32'd1);
      chk("t4_writes", g, 32'(wr_cnt[g]), 32'd0);
    end

    // 5: full-depth job with a start pulse mid-job
    run_job(8'h00, 8'h37, 9'd256, 100);
    for (int g = 0; g < NL; g++) begin
      chk("t5_writes", g, 32'(wr_cnt[g]), 32'd256);
      chk("t5_mem_last", g, 32'(mem_c[g][8'h36]), 32'(3 * 255));
      chk("t5_done_cyc", g, 32'(done_rel[g]), 32'(258 + g + 1));
    end

    // 6: reset during the third write
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    hit = '0;
    start = 1'b1; src = 8'h50; dst = 8'h90; len = 9'd8;
    step();
    start = 1'b0;
    n = 0;
    while (hit != '1 && n < 50) begin
      for (int g = 0; g < NL; g++) begin
        if (!hit[g] && ena_c_v[g] && addr_c_v[g] == 8'h92) begin
          hit[g]   = 1'b1;
          rst_v[g] = 1'b1;
        end
      end
      step();
      n++;
    end
    chk("t6_reset_hit", 0, 32'(hit), 32'(2'b11));
    step();
    rst_v = '0;
    step();
    step();
    for (int g = 0; g < NL; g++) begin
      chk("t6_mem0", g, 32'(mem_c[g][8'h90]), 32'h0F0);
      chk("t6_mem1", g, 32'(mem_c[g][8'h91]), 32'h0F3);
      for (int i = 2; i < 8; i++) chk("t6_untouched", g, 32'(mem_c[g][8'h90 + i]), 32'(16'hC090 + 16'(i)));
    end

    // random jobs over random operands
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] = 16'($urandom);
        mem_b[i] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) mem_a[i] = mem_a[i] | 16'hF000;
      end
      run_job(8'($urandom), 8'($urandom),
              ($urandom_range(0, 9) == 0) ? 9'd256 : 9'($urandom_range(0, 40)),
              int'($urandom_range(0, 30)));
      for (int w = $urandom_range(0, 3); w > 0; w--) step();
    end
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
